cache_port_arbiter: RTL and testbench

//  Shares one cache between two requesters: port 0 (instruction fetch) and port 1 (data memory stage).

---
 rtl/cache_port_arbiter_if.sv | 53 +++++
 rtl/cache_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter_if
// Bundles the two requester ports and the shared cache port of
// cache_port_arbiter.
//   pN_rd_req/pN_wr_req/pN_addr/pN_wr_data : requester N -> arbiter
//   pN_rd_data/pN_done                      : arbiter -> requester N
//   c_addr/c_rd_req/c_wr_req/c_wr_data      : arbiter -> cache
//   c_rd_data/c_miss                        : cache -> arbiter
// Modports: slave = arbiter view, master = requesters + cache view.
// -----------------------------------------------------------------------------
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_rd_req;
  logic              p0_wr_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wr_data;
  logic [DATA_W-1:0] p0_rd_data;
  logic              p0_done;

  logic              p1_rd_req;
  logic              p1_wr_req;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wr_data;
  logic [DATA_W-1:0] p1_rd_data;
  logic              p1_done;

  logic [ADDR_W-1:0] c_addr;
  logic              c_rd_req;
  logic              c_wr_req;
  logic [DATA_W-1:0] c_wr_data;
  logic [DATA_W-1:0] c_rd_data;
  logic              c_miss;

  modport slave (
    input  p0_rd_req, p0_wr_req, p0_addr, p0_wr_data,
    output p0_rd_data, p0_done,
    input  p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
    output p1_rd_data, p1_done,
    output c_addr, c_rd_req, c_wr_req, c_wr_data,
    input  c_rd_data, c_miss
  );

  modport master (
    output p0_rd_req, p0_wr_req, p0_addr, p0_wr_data,
    input  p0_rd_data, p0_done,
    output p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
    input  p1_rd_data, p1_done,
    input  c_addr, c_rd_req, c_wr_req, c_wr_data,
    output c_rd_data, c_miss
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
// Shares one cache between port 0 (instruction fetch) and port 1 (data stage).
// One request at a time is latched, driven to the cache and held while the
// cache reports a miss. Reads return data with a one-cycle done pulse; writes
// complete with a done pulse as soon as the cache accepts them.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : cache_port_arbiter_if.slave (both requester ports + cache port)
//   acc_cnt/miss_cnt/stall_cnt : statistics, only with CACHE_ARB_STATS_EN
//
// Parameters: ADDR_W, DATA_W, FIXED_PRIO (1: port 0 wins ties,
// 0: round-robin), CNT_W (statistics counter width).
//
// Optional feature macro: CACHE_ARB_STATS_EN adds saturating counters for
// completed transactions, missed transactions and miss-stall cycles.
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  cache_port_arbiter_if.slave bus
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e            state_q;
  // Owner of the current transaction; also the last grant for round-robin.
  // Resets to port 1 so that port 0 wins the first tie.
  logic              owner_q;
  logic [ADDR_W-1:0] c_addr_q;
  logic              c_rd_req_q;
  logic              c_wr_req_q;
  logic [DATA_W-1:0] c_wr_data_q;
  logic [DATA_W-1:0] p0_rd_data_q;
  logic [DATA_W-1:0] p1_rd_data_q;
  logic              p0_done_q;
  logic              p1_done_q;

  logic              elig0_s;
  logic              elig1_s;
  logic              gnt_any_s;
  logic              gnt_port_s;
  logic              gnt_rd_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic [DATA_W-1:0] gnt_wdata_s;

  // Arbitration: a port pulsing done this cycle is not eligible, so a
  // requester that drops its request one cycle late is not served twice.
  always_comb begin
    elig0_s   = (bus.p0_rd_req | bus.p0_wr_req) & ~p0_done_q;
    elig1_s   = (bus.p1_rd_req | bus.p1_wr_req) & ~p1_done_q;
    gnt_any_s = elig0_s | elig1_s;

    if (elig0_s && elig1_s) begin
      if (FIXED_PRIO != 0) begin
        gnt_port_s = 1'b0;
      end else begin
        gnt_port_s = ~owner_q;
      end
    end else if (elig1_s) begin
      gnt_port_s = 1'b1;
    end else begin
      gnt_port_s = 1'b0;
    end

    // rd and wr both high is treated as a read.
    if (gnt_port_s) begin
      gnt_rd_s    = bus.p1_rd_req;
      gnt_addr_s  = bus.p1_addr;
      gnt_wdata_s = bus.p1_wr_data;
    end else begin
      gnt_rd_s    = bus.p0_rd_req;
      gnt_addr_s  = bus.p0_addr;
      gnt_wdata_s = bus.p0_wr_data;
    end
  end

  // Transaction sequencer: IDLE grants and latches, ISSUE holds the cache
  // request until accepted, RESP captures read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b1;
      c_addr_q     <= {ADDR_W{1'b0}};
      c_rd_req_q   <= 1'b0;
      c_wr_req_q   <= 1'b0;
      c_wr_data_q  <= {DATA_W{1'b0}};
      p0_rd_data_q <= {DATA_W{1'b0}};
      p1_rd_data_q <= {DATA_W{1'b0}};
      p0_done_q    <= 1'b0;
      p1_done_q    <= 1'b0;
    end else begin
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any_s) begin
            owner_q     <= gnt_port_s;
            c_addr_q    <= gnt_addr_s;
            c_wr_data_q <= gnt_wdata_s;
            c_rd_req_q  <= gnt_rd_s;
            c_wr_req_q  <= ~gnt_rd_s;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.c_miss) begin
            c_rd_req_q <= 1'b0;
            c_wr_req_q <= 1'b0;
            if (c_wr_req_q) begin
              if (owner_q) begin
                p1_done_q <= 1'b1;
              end else begin
                p0_done_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          // The cache registered its read data on the accepting edge.
          if (owner_q) begin
            p1_rd_data_q <= bus.c_rd_data;
            p1_done_q    <= 1'b1;
          end else begin
            p0_rd_data_q <= bus.c_rd_data;
            p0_done_q    <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          c_rd_req_q <= 1'b0;
          c_wr_req_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.c_addr     = c_addr_q;
  assign bus.c_rd_req   = c_rd_req_q;
  assign bus.c_wr_req   = c_wr_req_q;
  assign bus.c_wr_data  = c_wr_data_q;
  assign bus.p0_rd_data = p0_rd_data_q;
  assign bus.p1_rd_data = p1_rd_data_q;
  assign bus.p0_done    = p0_done_q;
  assign bus.p1_done    = p1_done_q;

`ifdef CACHE_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [CNT_W-1:0] acc_cnt_q,   acc_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q,  miss_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             first_q;
  logic             issue_miss_s;
  logic             complete_s;

  // Counter next-state: completions, first-cycle misses, miss stall cycles.
  always_comb begin
    issue_miss_s = (state_q == ST_ISSUE) && bus.c_miss;
    complete_s   = ((state_q == ST_ISSUE) && !bus.c_miss && c_wr_req_q) ||
                   (state_q == ST_RESP);
    if (complete_s) begin
      acc_cnt_d = sat_inc(acc_cnt_q);
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
    if (issue_miss_s && first_q) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
    if (issue_miss_s) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers; first_q marks the first ISSUE cycle after a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q   <= {CNT_W{1'b0}};
      miss_cnt_q  <= {CNT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      first_q     <= 1'b0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      first_q     <= (state_q == ST_IDLE) && gnt_any_s;
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_port_arbiter
// Drives both requester ports and plays the cache. A transaction-level model
// predicts, from grant time and the miss length chosen for each transaction,
// when the cache request is visible and when done fires; outputs are compared
// every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FIXED_PRIO = 0;
  localparam int CNT_W      = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

`ifdef CACHE_ARB_STATS_EN
  logic [CNT_W-1:0] acc_cnt, miss_cnt, stall_cnt;
  int s_acc, s_miss, s_stall;
`endif

  cache_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(FIXED_PRIO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef CACHE_ARB_STATS_EN
    ,
    .acc_cnt(acc_cnt),
    .miss_cnt(miss_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;
  int force_m = -1;

  // requesters
  bit                act [2];
  bit                drop_next [2];
  logic              r_rd [2];
  logic              r_wr [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_wd [2];

  // transaction model
  bit                tx_valid;
  int                tx_g, tx_m, tx_done;
  bit                tx_port, tx_rd;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_wd, tx_rdval;
  bit                m_last;
  logic [DATA_W-1:0] m_rd [2];
  logic [DATA_W-1:0] mem [16];

  // observed values of the most recent cycle
  logic              o_crd, o_cwr;
  logic [ADDR_W-1:0] o_addr;
  logic              o_done [2];
  logic [DATA_W-1:0] o_rd [2];

  function automatic int idx(input logic [ADDR_W-1:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  task automatic drive_reqs();
    bus_if.p0_rd_req  = r_rd[0];
    bus_if.p0_wr_req  = r_wr[0];
    bus_if.p0_addr    = r_addr[0];
    bus_if.p0_wr_data = r_wd[0];
    bus_if.p1_rd_req  = r_rd[1];
    bus_if.p1_wr_req  = r_wr[1];
    bus_if.p1_addr    = r_addr[1];
    bus_if.p1_wr_data = r_wd[1];
  endtask

  task automatic clear_req(input int p);
    act[p] = 1'b0; drop_next[p] = 1'b0;
    r_rd[p] = 1'b0; r_wr[p] = 1'b0;
    r_addr[p] = '0; r_wd[p] = '0;
  endtask

  task automatic new_req(input int p, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    act[p] = 1'b1; drop_next[p] = 1'b0;
    r_rd[p] = rd; r_wr[p] = wr; r_addr[p] = a; r_wd[p] = d;
  endtask

  task automatic model_reset();
    tx_valid = 1'b0;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
    clear_req(0);
    clear_req(1);
`ifdef CACHE_ARB_STATS_EN
    s_acc = 0; s_miss = 0; s_stall = 0;
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c_rd_req"},  64'(bus_if.c_rd_req), 64'(0));
    chk({tag, "_c_wr_req"},  64'(bus_if.c_wr_req), 64'(0));
    chk({tag, "_c_addr"},    64'(bus_if.c_addr), 64'(0));
    chk({tag, "_c_wr_data"}, 64'(bus_if.c_wr_data), 64'(0));
    chk({tag, "_p0_done"},   64'(bus_if.p0_done), 64'(0));
    chk({tag, "_p1_done"},   64'(bus_if.p1_done), 64'(0));
    chk({tag, "_p0_rd"},     64'(bus_if.p0_rd_data), 64'(0));
    chk({tag, "_p1_rd"},     64'(bus_if.p1_rd_data), 64'(0));
`ifdef CACHE_ARB_STATS_EN
    chk({tag, "_acc"},   64'(acc_cnt), 64'(0));
    chk({tag, "_miss"},  64'(miss_cnt), 64'(0));
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(0));
`endif
  endtask

  // One clock cycle: predict, drive, arbitrate in the model, compare.
  // Entered just after a rising edge; returns just after the next one.
  task automatic run_cycle();
    bit e_done [2];
    bit e_win, e0, e1, gp;
    bit e_crd, e_cwr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    int win_end;
    e_done[0] = 1'b0;
    e_done[1] = 1'b0;
    e_win = 1'b0;
    win_end = 0;
    if (tx_valid) begin
      win_end = tx_g + 1 + tx_m;
      e_win = (cyc >= tx_g + 1) && (cyc <= win_end);
      if (cyc == tx_done) begin
        e_done[tx_port] = 1'b1;
        if (tx_rd) m_rd[tx_port] = tx_rdval;
        else mem[idx(tx_addr)] = tx_wd;
`ifdef CACHE_ARB_STATS_EN
        s_acc++;
`endif
      end
`ifdef CACHE_ARB_STATS_EN
      if (tx_m > 0 && cyc == tx_g + 2) s_miss++;
      if (cyc >= tx_g + 2 && cyc <= tx_g + 1 + tx_m) s_stall++;
`endif
    end
    e_crd = e_win && tx_rd;
    e_cwr = e_win && !tx_rd;
    e_addr = tx_addr;
    e_wd = tx_wd;

    // cache side: miss only matters inside the request window
    if (e_win) bus_if.c_miss = (cyc < win_end);
    else bus_if.c_miss = 1'($urandom);
    if (tx_valid && tx_rd && cyc == tx_g + 2 + tx_m) bus_if.c_rd_data = tx_rdval;
    else bus_if.c_rd_data = $urandom;

    // requesters hold through the done cycle, drop the cycle after
    for (int p = 0; p < 2; p++) begin
      if (drop_next[p]) clear_req(p);
      if (rand_mode && !act[p] && $urandom_range(0, 2) == 0) begin
        int k;
        k = int'($urandom_range(0, 2));
        new_req(p, k != 1, k != 0, $urandom, $urandom);
      end
      if (e_done[p]) drop_next[p] = 1'b1;
    end
    drive_reqs();

    // model arbitration
    if (!tx_valid || cyc >= tx_done) begin
      tx_valid = 1'b0;
      e0 = act[0] && !e_done[0];
      e1 = act[1] && !e_done[1];
      if (e0 || e1) begin
        if (e0 && e1) gp = (FIXED_PRIO != 0) ? 1'b0 : !m_last;
        else gp = e1;
        m_last   = gp;
        tx_valid = 1'b1;
        tx_g     = cyc;
        tx_port  = gp;
        tx_rd    = r_rd[gp];
        tx_addr  = r_addr[gp];
        tx_wd    = r_wd[gp];
        if (force_m >= 0) tx_m = force_m;
        else tx_m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        force_m  = -1;
        tx_done  = tx_g + (tx_rd ? 3 : 2) + tx_m;
        tx_rdval = mem[idx(tx_addr)];
      end
    end

    @(negedge clk);
    o_crd = bus_if.c_rd_req;
    o_cwr = bus_if.c_wr_req;
    o_addr = bus_if.c_addr;
    o_done[0] = bus_if.p0_done;
    o_done[1] = bus_if.p1_done;
    o_rd[0] = bus_if.p0_rd_data;
    o_rd[1] = bus_if.p1_rd_data;
    chk("c_rd_req", 64'(o_crd), 64'(e_crd));
    chk("c_wr_req", 64'(o_cwr), 64'(e_cwr));
    if (e_win) begin
      chk("c_addr", 64'(o_addr), 64'(e_addr));
      chk("c_wr_data", 64'(bus_if.c_wr_data), 64'(e_wd));
    end
    chk("p0_done", 64'(o_done[0]), 64'(e_done[0]));
    chk("p1_done", 64'(o_done[1]), 64'(e_done[1]));
    chk("p0_rd_data", 64'(o_rd[0]), 64'(m_rd[0]));
    chk("p1_rd_data", 64'(o_rd[1]), 64'(m_rd[1]));
`ifdef CACHE_ARB_STATS_EN
    chk("acc_cnt", 64'(acc_cnt), 64'(s_acc));
    chk("miss_cnt", 64'(miss_cnt), 64'(s_miss));
    chk("stall_cnt", 64'(stall_cnt), 64'(s_stall));
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ports_done(input int need, output int first_p);
    int seen;
    seen = 0;
    first_p = -1;
    for (int i = 0; i < 200 && (seen & need) != need; i++) begin
      run_cycle();
      if (o_done[0]) begin if (first_p < 0) first_p = 0; seen |= 1; end
      if (o_done[1]) begin if (first_p < 0) first_p = 1; seen |= 2; end
    end
    chk("done_within_budget", 64'((seen & need) == need), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((act[0] || act[1] || (tx_valid && cyc <= tx_done)) && n < 300) begin
      run_cycle();
      n++;
    end
    chk("drain_within_budget", 64'(n < 300), 64'(1));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    drive_reqs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fp, cnt, cnt0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    bus_if.c_miss = 1'b0;
    bus_if.c_rd_data = '0;
    apply_reset();

    // Two simultaneous requests after reset: port 0 first, then port 1.
    new_req(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    new_req(1, 1'b0, 1'b1, 32'h0000_0208, 32'hA5A5_0001);
    force_m = 0;
    run_cycle();
    run_cycle();
    chk("t2_first_is_p0_read", 64'(o_crd), 64'(1));
    chk("t2_first_addr", 64'(o_addr), 64'(32'h0000_0104));
    wait_ports_done(3, fp);
    chk("t2_order_a", 64'(fp), 64'(0));
    run_cycle();
    // port 0 alone, then a tie: round-robin favours port 1 now
    new_req(0, 1'b0, 1'b1, 32'h0000_010C, 32'h1111_2222);
    wait_ports_done(1, fp);
    run_cycle();
    new_req(0, 1'b1, 1'b0, 32'h0000_0110, 32'h0);
    new_req(1, 1'b1, 1'b1, 32'h0000_0214, 32'h0);
    wait_ports_done(3, fp);
    chk("t2_order_b", 64'(fp), 64'((FIXED_PRIO != 0) ? 0 : 1));
    drain();

    // Warm-line read; request held through done and dropped after.
    mem[idx(32'h40)] = 32'h0000_1234;
    new_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    force_m = 0;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      run_cycle();
      if (o_crd) cnt++;
      if (i == 1) chk("t1_c_rd_req_cycle1", 64'(o_crd), 64'(1));
      if (i == 2) chk("t1_no_done_cycle2", 64'(o_done[0]), 64'(0));
      if (i == 3) begin
        chk("t1_done_cycle3", 64'(o_done[0]), 64'(1));
        chk("t1_rd_data", 64'(o_rd[0]), 64'(32'h0000_1234));
      end
    end
    chk("t4_single_access", 64'(cnt), 64'(1));

    // Long miss on port 1 with port 0 waiting.
    new_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    force_m = 20;
    cnt = 0;
    cnt0 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) new_req(0, 1'b0, 1'b1, 32'h0000_0044, 32'hBEEF_0003);
      run_cycle();
      if (o_crd && o_addr == 32'h0000_0300) cnt++;
      if (i <= 23 && o_done[0]) cnt0++;
      if (i == 22) chk("t3_no_done_early", 64'(o_done[1]), 64'(0));
      if (i == 23) chk("t3_done_2_after_miss", 64'(o_done[1]), 64'(1));
    end
    chk("t3_req_cycles", 64'(cnt), 64'(21));
    chk("t3_p0_not_served", 64'(cnt0), 64'(0));
    drain();

    // Randomised traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) run_cycle();
    rand_mode = 1'b0;
    drain();

    // Reset in the middle of a missing read.
    new_req(0, 1'b1, 1'b0, 32'h0000_0084, 32'h0);
    force_m = 10;
    run_cycle();
    run_cycle();
    chk("t5_in_issue", 64'(o_crd), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    drive_reqs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Recovery: three hits then one 5-cycle miss.
    mem[idx(32'h88)] = 32'hCAFE_0005;
    new_req(0, 1'b1, 1'b0, 32'h0000_0088, 32'h0);
    force_m = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      if (i == 3) begin
        chk("t5_post_done", 64'(o_done[0]), 64'(1));
        chk("t5_post_data", 64'(o_rd[0]), 64'(32'hCAFE_0005));
      end
    end
    for (int n = 0; n < 3; n++) begin
      run_cycle();
      if (n == 2) begin
        new_req(1, 1'b1, 1'b0, 32'h0000_0090, 32'h0);
        force_m = 5;
      end else begin
        new_req(n, 1'b0, 1'b1, 32'h0000_008C, 32'h7777_0000);
        force_m = 0;
      end
      wait_ports_done((n == 2) ? 2 : (1 << n), fp);
    end
    drain();
`ifdef CACHE_ARB_STATS_EN
    chk("t6_acc_cnt", 64'(acc_cnt), 64'(4));
    chk("t6_miss_cnt", 64'(miss_cnt), 64'(1));
    chk("t6_stall_cnt", 64'(stall_cnt), 64'(5));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
